// File: rtl/cpu_pkg.sv
// Shared definitions for the simple_cpu front end: instruction classes,
// per-class hold lengths and the fetch sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_WIDTH = 20;
    localparam int PC_BITS     = 5;
    localparam int STD_CYCLES  = 3;
    localparam int MEM_CYCLES  = 4;

    localparam logic [1:0] CLS_HALT  = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/instr_rom.sv
// Program store: synchronous write port, combinational read port.
// Contents survive reset so a loaded program can be rerun.
module instr_rom #(
    parameter int AW = 5,
    parameter int DW = 20
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction sequencer for simple_cpu: walks the program store and holds
// each instruction for exactly as many cycles as the CU needs for its class.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter int PC_BITS     = cpu_pkg::PC_BITS,
    parameter int STD_CYCLES  = cpu_pkg::STD_CYCLES,
    parameter int MEM_CYCLES  = cpu_pkg::MEM_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_en,
    input  logic [PC_BITS-1:0]     load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   start,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_BITS-1:0]     pc,
    output logic                   issue,
    output logic                   busy,
    output logic                   halted,
    output logic [1:0]             dbg_state
);

    localparam int MAX_CYCLES = (STD_CYCLES > MEM_CYCLES) ? STD_CYCLES : MEM_CYCLES;
    localparam int HW         = $clog2(MAX_CYCLES + 2);

    fetch_state_e           r_state, w_state_nxt;
    logic [PC_BITS-1:0]     r_pc, w_pc_nxt, w_rd_addr;
    logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt, w_rd_data;
    logic                   r_issue, w_issue_nxt;
    logic [HW-1:0]          r_hold, w_hold_nxt;
    logic                   w_we, w_start, w_first_extra;
    logic [1:0]             w_cls;

    function automatic logic [HW-1:0] hold_of(input logic [1:0] cls);
        return (cls == CLS_STD) ? HW'(STD_CYCLES) : HW'(MEM_CYCLES);
    endfunction

    // Loads and starts are only honoured while not running; a load wins over a start.
    assign w_we      = load_en && (r_state != RUN);
    assign w_start   = start && !load_en && (r_state != RUN);
    assign w_rd_addr = (r_state == RUN) ? (r_pc + PC_BITS'(1)) : '0;
    assign w_cls     = w_rd_data[INSTR_WIDTH-1 -: 2];
    // Only a start out of IDLE pays the extra cycle for the CU leaving RESET.
    assign w_first_extra = (r_state == IDLE);

    instr_rom #(
        .AW(PC_BITS),
        .DW(INSTR_WIDTH)
    ) u_rom (
        .clk    (clk),
        .i_we   (w_we),
        .i_waddr(load_addr),
        .i_wdata(load_data),
        .i_raddr(w_rd_addr),
        .o_rdata(w_rd_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_issue_nxt = 1'b0;
        w_hold_nxt  = r_hold;
        case (r_state)
            IDLE, HALT: begin
                if (w_start) begin
                    w_pc_nxt = '0;
                    if (w_cls == CLS_HALT) begin
                        w_state_nxt = HALT;
                        w_instr_nxt = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_state_nxt = RUN;
                        w_instr_nxt = w_rd_data;
                        w_issue_nxt = 1'b1;
                        w_hold_nxt  = hold_of(w_cls) + HW'(w_first_extra);
                    end
                end
            end
            RUN: begin
                if (r_hold == HW'(1)) begin
                    w_pc_nxt = r_pc + PC_BITS'(1);
                    if (w_cls == CLS_HALT) begin
                        w_state_nxt = HALT;
                        w_instr_nxt = '0;
                        w_hold_nxt  = '0;
                    end else begin
                        w_instr_nxt = w_rd_data;
                        w_issue_nxt = 1'b1;
                        w_hold_nxt  = hold_of(w_cls);
                    end
                end else begin
                    w_hold_nxt = r_hold - HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_pc_nxt    = '0;
                w_instr_nxt = '0;
                w_hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_pc    <= '0;
            r_instr <= '0;
            r_issue <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_issue <= w_issue_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    assign instruction = r_instr;
    assign pc          = r_pc;
    assign issue       = r_issue;
    assign busy        = (r_state == RUN);
    assign halted      = (r_state == HALT);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed + randomized bench for instr_fetch; the reference model expands the
// program into a per-cycle trace of (instruction, pc, issue, busy, halted).
module tb_instr_fetch;

    localparam int IW = 20;
    localparam int PB = 5;
    localparam int D  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [PB-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          start;
    logic [IW-1:0] instruction;
    logic [PB-1:0] pc;
    logic          issue;
    logic          busy;
    logic          halted;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [IW-1:0] tb_mem [0:D-1];
    // Packed trace entry: {instruction[19:0], pc[4:0], issue, busy, halted}
    logic [27:0]   exp_q[$];

    instr_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .instruction(instruction),
        .pc         (pc),
        .issue      (issue),
        .busy       (busy),
        .halted     (halted),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input int a, input logic [IW-1:0] d);
        load_en   = 1'b1;
        load_addr = a[PB-1:0];
        load_data = d;
        tick();
        load_en   = 1'b0;
        tb_mem[a] = d;
    endtask

    function automatic int cls_cycles(input logic [IW-1:0] w);
        return (w[IW-1:IW-2] == 2'b01) ? 3 : 4;
    endfunction

    // Expand the program into the cycle-by-cycle outputs seen after start.
    task automatic build_expect(input bit from_idle, input int n);
        int pc_m;
        bit first;
        int dur;
        logic [IW-1:0] w;
        pc_m  = 0;
        first = 1'b1;
        exp_q.delete();
        while (exp_q.size() < n) begin
            w = tb_mem[pc_m];
            if (w[IW-1:IW-2] == 2'b00) begin
                while (exp_q.size() < n)
                    exp_q.push_back({20'h0, pc_m[PB-1:0], 1'b0, 1'b0, 1'b1});
            end else begin
                dur = cls_cycles(w) + ((first && from_idle) ? 1 : 0);
                for (int k = 0; k < dur && exp_q.size() < n; k++)
                    exp_q.push_back({w, pc_m[PB-1:0], (k == 0), 1'b1, 1'b0});
                pc_m  = (pc_m + 1) % D;
                first = 1'b0;
            end
        end
    endtask

    task automatic run_prog(input bit from_idle, input int n, input bit disturb, input string tag);
        logic [27:0] e;
        build_expect(from_idle, n);
        start = 1'b1;
        tick();
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "/instr"},  32'(instruction), 32'(e[27:8]));
            check({tag, "/pc"},     32'(pc),          32'(e[7:3]));
            check({tag, "/issue"},  32'(issue),       32'(e[2]));
            check({tag, "/busy"},   32'(busy),        32'(e[1]));
            check({tag, "/halted"}, 32'(halted),      32'(e[0]));
            if (disturb && e[1]) begin
                load_en   = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                load_addr = PB'($urandom_range(0, D - 1));
                load_data = IW'($urandom);
            end else begin
                load_en = 1'b0;
                start   = 1'b0;
            end
            tick();
        end
        load_en = 1'b0;
        start   = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "/instr"},  32'(instruction), 32'h0);
        check({tag, "/pc"},     32'(pc),          32'h0);
        check({tag, "/issue"},  32'(issue),       32'h0);
        check({tag, "/busy"},   32'(busy),        32'h0);
        check({tag, "/halted"}, 32'(halted),      32'h0);
        check({tag, "/state"},  32'(dbg_state),   32'h0);
    endtask

    initial begin
        logic [IW-1:0] w;
        int hpos;
        rst       = 1'b0;
        load_en   = 1'b0;
        start     = 1'b0;
        load_addr = '0;
        load_data = '0;
        tick();
        tick();
        rst = 1'b1;
        check_reset("por");

        // Single std word then halt: 4-cycle first hold from IDLE.
        load_word(0, 20'h4_1230);
        load_word(1, 20'h0_0000);
        run_prog(1'b1, 8, 1'b0, "t2");

        // Mixed classes started from HALT (no extra first cycle).
        load_word(0, 20'h9_0050);
        load_word(1, 20'hD_0060);
        load_word(2, 20'h4_1000);
        load_word(3, 20'h0_0000);
        run_prog(1'b0, 16, 1'b0, "t3h");

        // Reset held 2 cycles in the middle of a run.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        check_reset("t1");
        // Same program from IDLE: holds 5,4,3 and memory survived reset.
        run_prog(1'b1, 16, 1'b0, "t3");

        // Full-depth std program wraps 31 -> 0; load/start noise while running.
        for (int i = 0; i < D; i++)
            load_word(i, {2'b01, 18'($urandom)});
        run_prog(1'b0, 3 * D + 12, 1'b1, "t4");
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset("t4rst");
        load_word(7, 20'h0_0000);
        run_prog(1'b1, 30, 1'b1, "t5");

        // Load and start together in HALT: load wins, start ignored.
        w         = {2'b10, 18'($urandom)};
        load_en   = 1'b1;
        start     = 1'b1;
        load_addr = '0;
        load_data = w;
        tick();
        load_en   = 1'b0;
        start     = 1'b0;
        tb_mem[0] = w;
        check("t6/halted", 32'(halted), 32'h1);
        check("t6/busy",   32'(busy),   32'h0);
        check("t6/issue",  32'(issue),  32'h0);
        check("t6/instr",  32'(instruction), 32'h0);
        run_prog(1'b0, 30, 1'b0, "t6");

        // Random programs of mixed classes with a halt somewhere in 6..11.
        for (int r = 0; r < 4; r++) begin
            hpos = $urandom_range(6, 11);
            for (int i = 0; i < 12; i++) begin
                if (i == hpos)
                    load_word(i, 20'h0_0000);
                else
                    load_word(i, {2'($urandom_range(1, 3)), 18'($urandom)});
            end
            run_prog(1'b0, 56, (r % 2) == 1, "t7");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
